bus_arbiter: RTL



---
 rtl/bus_arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter_if.sv | 48 ++++
 rtl/bus_arbiter_rr_select.sv | 38 +++
 rtl/bus_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and default frame constants for the CPU/Wishbone time-slot arbiter.
// Contents: arb_state_t FSM encoding, default parameter values, index-width helper.
// Imported by the interface, the round-robin picker and the arbiter top.
package bus_arbiter_pkg;

  localparam int DEF_NUM_INITIATORS = 2;
  localparam int DEF_FRAME_CYCLES   = 64;
  localparam int DEF_WB_CYCLES      = 32;
  localparam int DEF_GUARD_CYCLES   = 4;
  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } arb_state_t;

  // Width of an initiator index; at least one bit even for a single initiator.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the initiator-side and target-side Wishbone signals plus the 6502 timing outputs.
// master: the arbiter's view (drives responses, target requests, cpu_be_o/cpu_clock_o).
// slave: the surrounding system's view (initiators, downstream target, CPU).
interface bus_arbiter_if import bus_arbiter_pkg::*; #(
  parameter int NUM_INITIATORS = DEF_NUM_INITIATORS,
  parameter int WB_ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
);

  logic [NUM_INITIATORS*WB_ADDR_WIDTH-1:0] ini_addr_i;
  logic [NUM_INITIATORS*DATA_WIDTH-1:0]    ini_data_i;
  logic [NUM_INITIATORS-1:0]               ini_we_i;
  logic [NUM_INITIATORS-1:0]               ini_cycle_i;
  logic [NUM_INITIATORS-1:0]               ini_strobe_i;
  logic [NUM_INITIATORS-1:0]               ini_stall_o;
  logic [NUM_INITIATORS-1:0]               ini_ack_o;
  logic [NUM_INITIATORS-1:0]               ini_err_o;
  logic [DATA_WIDTH-1:0]                   ini_data_o;

  logic [WB_ADDR_WIDTH-1:0]                tgt_addr_o;
  logic [DATA_WIDTH-1:0]                   tgt_data_o;
  logic                                    tgt_we_o;
  logic                                    tgt_cycle_o;
  logic                                    tgt_strobe_o;
  logic                                    tgt_stall_i;
  logic                                    tgt_ack_i;
  logic [DATA_WIDTH-1:0]                   tgt_data_i;

  logic                                    cpu_be_o;
  logic                                    cpu_clock_o;

  modport master (
    input  ini_addr_i, ini_data_i, ini_we_i, ini_cycle_i, ini_strobe_i,
    output ini_stall_o, ini_ack_o, ini_err_o, ini_data_o,
    output tgt_addr_o, tgt_data_o, tgt_we_o, tgt_cycle_o, tgt_strobe_o,
    input  tgt_stall_i, tgt_ack_i, tgt_data_i,
    output cpu_be_o, cpu_clock_o
  );

  modport slave (
    output ini_addr_i, ini_data_i, ini_we_i, ini_cycle_i, ini_strobe_i,
    input  ini_stall_o, ini_ack_o, ini_err_o, ini_data_o,
    input  tgt_addr_o, tgt_data_o, tgt_we_o, tgt_cycle_o, tgt_strobe_o,
    output tgt_stall_i, tgt_ack_i, tgt_data_i,
    input  cpu_be_o, cpu_clock_o
  );

endinterface

// File: rtl/bus_arbiter_rr_select.sv
// Round-robin picker: first asserted request at index >= ptr, wrapping to index 0.
// Latency: combinational. Backpressure: none, pure function of req and ptr.
// Ports: req (request vector), ptr (priority start), vld (any request), idx (winner).
module bus_arbiter_rr_select import bus_arbiter_pkg::*; #(
  parameter int NUM_INITIATORS = DEF_NUM_INITIATORS,
  parameter int IDX_W          = idx_width(NUM_INITIATORS)
) (
  input  logic [NUM_INITIATORS-1:0] req,
  input  logic [IDX_W-1:0]          ptr,
  output logic                      vld,
  output logic [IDX_W-1:0]          idx
);

  logic             hi_found;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Two lowest-index searches: one restricted to indices >= ptr, one unrestricted.
  // The restricted hit wins; otherwise the search has wrapped past the top.
  always_comb begin
    hi_found = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_INITIATORS - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          idx_hi   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign vld = |req;
  assign idx = hi_found ? idx_hi : idx_lo;

endmodule

// File: rtl/bus_arbiter.sv
// Frame-based arbiter: 6502 bus-enable/PHI2 timing plus round-robin sharing of the WB window.
// Latency: request in IDLE -> tgt_strobe_o next cycle; ack passes through same cycle; 3-cycle minimum turnaround.
// Backpressure: tgt_stall_i holds ISSUE; no start within the guard band; overrun of the WB window aborts with ini_err_o.
// Ports: wb_clock_i, wb_reset_i (async, active-high), bus (master view of bus_arbiter_if).
module bus_arbiter import bus_arbiter_pkg::*; #(
  parameter int NUM_INITIATORS = DEF_NUM_INITIATORS,
  parameter int FRAME_CYCLES   = DEF_FRAME_CYCLES,
  parameter int WB_CYCLES      = DEF_WB_CYCLES,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int WB_ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic            wb_clock_i,
  input  logic            wb_reset_i,
  bus_arbiter_if.master   bus
);

  localparam int IDX_W      = idx_width(NUM_INITIATORS);
  localparam int CNT_W      = $clog2(FRAME_CYCLES);
  localparam int PHI2_START = WB_CYCLES + (FRAME_CYCLES - WB_CYCLES) / 2;

  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      cpu_be_q, cpu_clk_q;
  arb_state_t                state, state_nxt;
  logic [IDX_W-1:0]          sel, sel_nxt, ptr, ptr_nxt, sel_inc, pick_idx;
  logic                      pick_vld, latch, win_last, can_start;
  logic                      tgt_cyc, tgt_stb;
  logic [NUM_INITIATORS-1:0] req, sel_onehot, stall, ack, err_nxt, err_q;
  logic [WB_ADDR_WIDTH-1:0]  addr_pick, addr_q;
  logic [DATA_WIDTH-1:0]     data_pick, data_q;
  logic                      we_pick, we_q;

  // Frame counter and CPU timing. Both CPU outputs are decoded from the next count
  // so the registered versions line up with the current count.
  assign cnt_nxt = (cnt == CNT_W'(FRAME_CYCLES - 1)) ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      cnt       <= '0;
      cpu_be_q  <= 1'b0;
      cpu_clk_q <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      cpu_be_q  <= (cnt_nxt >= CNT_W'(WB_CYCLES));
      cpu_clk_q <= (cnt_nxt >= CNT_W'(PHI2_START));
    end
  end

  assign req      = bus.ini_cycle_i & bus.ini_strobe_i;
  assign win_last = (cnt == CNT_W'(WB_CYCLES - 1));
  // A start on the last WB cycle would put ISSUE inside the CPU window, so the
  // start window also stops one short of the end when GUARD_CYCLES is 1.
  assign can_start = (cnt <= CNT_W'(WB_CYCLES - GUARD_CYCLES)) &&
                     (cnt < CNT_W'(WB_CYCLES - 1));
  assign sel_inc = (sel == IDX_W'(NUM_INITIATORS - 1)) ? '0 : sel + IDX_W'(1);

  bus_arbiter_rr_select #(
    .NUM_INITIATORS (NUM_INITIATORS),
    .IDX_W          (IDX_W)
  ) u_rr_select (
    .req (req),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    addr_pick  = '0;
    data_pick  = '0;
    we_pick    = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_INITIATORS; i++) begin
      sel_onehot[i] = (sel == IDX_W'(i));
      if (pick_idx == IDX_W'(i)) begin
        addr_pick = bus.ini_addr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        data_pick = bus.ini_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        we_pick   = bus.ini_we_i[i];
      end
    end
  end

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state  <= IDLE;
      sel    <= '0;
      ptr    <= '0;
      err_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      err_q <= err_nxt;
      if (latch) begin
        addr_q <= addr_pick;
        data_q <= data_pick;
        we_q   <= we_pick;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    err_nxt   = '0;
    latch     = 1'b0;
    tgt_cyc   = 1'b0;
    tgt_stb   = 1'b0;
    stall     = '1;
    ack       = '0;
    case (state)
      IDLE: begin
        if (can_start && pick_vld) begin
          sel_nxt   = pick_idx;
          latch     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tgt_cyc = 1'b1;
        tgt_stb = 1'b1;
        if (!bus.tgt_stall_i) begin
          stall     = ~sel_onehot;
          state_nxt = WAIT_ACK;
        end
        // No ack can arrive in ISSUE, so reaching the window end here always aborts.
        if (win_last) begin
          state_nxt = IDLE;
          ptr_nxt   = sel_inc;
          err_nxt   = sel_onehot;
        end
      end
      WAIT_ACK: begin
        tgt_cyc = 1'b1;
        if (bus.tgt_ack_i) begin
          // An initiator that has dropped its cycle no longer wants the ack.
          ack       = sel_onehot & bus.ini_cycle_i;
          ptr_nxt   = sel_inc;
          state_nxt = IDLE;
        end else if (win_last) begin
          state_nxt = IDLE;
          ptr_nxt   = sel_inc;
          err_nxt   = sel_onehot;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ini_stall_o  = stall;
  assign bus.ini_ack_o    = ack;
  assign bus.ini_err_o    = err_q;
  assign bus.ini_data_o   = bus.tgt_data_i;
  assign bus.tgt_addr_o   = addr_q;
  assign bus.tgt_data_o   = data_q;
  assign bus.tgt_we_o     = we_q;
  assign bus.tgt_cycle_o  = tgt_cyc;
  assign bus.tgt_strobe_o = tgt_stb;
  assign bus.cpu_be_o     = cpu_be_q;
  assign bus.cpu_clock_o  = cpu_clk_q;

endmodule
